vram_port_arbiter: RTL and testbench

- Shares the single-port vector RAM BRAM between two requesters: the CPU store-queue drain (writes) and the vector generator (reads).
- Sits between the CPU-side store queue (data/addr/empty in, canWrite pop strobe out) and the BRAM_VECTOR port.
- Vector generator has priority while drawing, with a starvation bound for the CPU.
- On each vector-generator start strobe, the queue is flushed completely before drawing begins, so the generator sees a consistent display list.

---
 rtl/vram_arb_pkg.sv | 19 +
 rtl/vram_rd_pipe.sv | 28 ++
 rtl/vram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_vram_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the vector-RAM port arbiter.
// Defines the arbiter states and the CPU address window that maps onto vector RAM.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    S_CPU_ONLY = 2'd0,
    S_FLUSH    = 2'd1,
    S_SHARED   = 2'd2
  } arb_state_e;

  localparam logic [15:0] VRAM_BASE = 16'h2000;
  localparam logic [15:0] VRAM_LAST = 16'h3FFF;

  // True when a CPU address lands inside the vector RAM window.
  function automatic logic in_vram(input logic [15:0] addr);
    return (addr >= VRAM_BASE) && (addr <= VRAM_LAST);
  endfunction

endpackage

// File: rtl/vram_rd_pipe.sv
// Read-valid shift register that tracks BRAM reads in flight.
// A token entering on issue appears on rvalid DEPTH cycles later.
module vram_rd_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic rvalid
);

  logic [DEPTH-1:0] valid_q;

  // Reset discards every read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= issue;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign rvalid = valid_q[DEPTH-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// Arbitrates the single-port vector RAM between the CPU store-queue drain and
// the vector generator, flushing the queue on every generator start.
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_empty,
  input  logic [15:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_can_write,
  input  logic              vg_go,
  input  logic              vg_busy,
  input  logic              vg_req,
  input  logic [ADDR_W-1:0] vg_addr,
  output logic              vg_ack,
  output logic [DATA_W-1:0] vg_rdata,
  output logic              vg_rvalid,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              flushing,
  output logic              err_unmapped
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              rd_issue_q, rd_issue_d;

  logic cpu_grant;
  logic vg_grant;
  logic cpu_starved;
  logic cpu_in_range;

  assign cpu_starved  = (starve_q == CNT_MAX) && !cpu_empty;
  assign cpu_in_range = in_vram(cpu_addr);

  // Grant decision; at most one requester wins, nobody wins during reset.
  always_comb begin
    cpu_grant = 1'b0;
    vg_grant  = 1'b0;
    case (state_q)
      S_CPU_ONLY: begin
        cpu_grant = !cpu_empty;
        vg_grant  = cpu_empty && vg_req;
      end
      S_FLUSH: begin
        cpu_grant = !cpu_empty;
      end
      S_SHARED: begin
        vg_grant  = vg_req && !cpu_starved;
        cpu_grant = !vg_grant && !cpu_empty;
      end
      default: begin
        cpu_grant = 1'b0;
        vg_grant  = 1'b0;
      end
    endcase
    if (rst) begin
      cpu_grant = 1'b0;
      vg_grant  = 1'b0;
    end
  end

  // Next state, starvation counter and BRAM port contents.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    din_d      = din_q;
    we_d       = 1'b0;
    err_d      = err_q;
    rd_issue_d = vg_grant;

    if (cpu_grant) begin
      addr_d = cpu_addr[ADDR_W-1:0];
      din_d  = cpu_data;
      we_d   = cpu_in_range;
      if (!cpu_in_range) begin
        err_d = 1'b1;
      end
    end else if (vg_grant) begin
      addr_d = vg_addr;
    end

    if (vg_go || cpu_grant) begin
      starve_d = '0;
    end else if (vg_grant && !cpu_empty && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end

    if (vg_go) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_FLUSH:    if (cpu_empty && !cpu_grant) state_d = S_SHARED;
        S_SHARED:   if (!vg_busy) state_d = S_CPU_ONLY;
        S_CPU_ONLY: if (vg_busy) state_d = S_SHARED;
        default:    state_d = S_CPU_ONLY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CPU_ONLY;
      starve_q   <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      rd_issue_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      err_q      <= err_d;
      rd_issue_q <= rd_issue_d;
    end
  end

  // rd_issue_q marks the BRAM address cycle; data follows RD_LAT cycles later.
  vram_rd_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .issue  (rd_issue_q),
    .rvalid (vg_rvalid)
  );

  assign cpu_can_write = cpu_grant;
  assign vg_ack        = vg_grant;
  assign vg_rdata      = bram_dout;
  assign bram_addr     = addr_q;
  assign bram_din      = din_q;
  assign bram_we       = we_q;
  assign flushing      = (state_q == S_FLUSH);
  assign err_unmapped  = err_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter: a store queue, a BRAM with read latency
// and a cycle-level reference model compared against the DUT on every cycle.
module tb_vram_port_arbiter;

  localparam int unsigned ADDR_W       = 13;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned RD_LAT       = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_empty = 1'b1;
  logic [15:0]       cpu_addr = '0;
  logic [DATA_W-1:0] cpu_data = '0;
  logic              cpu_can_write;
  logic              vg_go = 1'b0;
  logic              vg_busy = 1'b0;
  logic              vg_req = 1'b0;
  logic [ADDR_W-1:0] vg_addr = '0;
  logic              vg_ack;
  logic [DATA_W-1:0] vg_rdata;
  logic              vg_rvalid;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic [DATA_W-1:0] bram_dout;
  logic              flushing;
  logic              err_unmapped;

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .RD_LAT       (RD_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_empty     (cpu_empty),
    .cpu_addr      (cpu_addr),
    .cpu_data      (cpu_data),
    .cpu_can_write (cpu_can_write),
    .vg_go         (vg_go),
    .vg_busy       (vg_busy),
    .vg_req        (vg_req),
    .vg_addr       (vg_addr),
    .vg_ack        (vg_ack),
    .vg_rdata      (vg_rdata),
    .vg_rvalid     (vg_rvalid),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_we       (bram_we),
    .bram_dout     (bram_dout),
    .flushing      (flushing),
    .err_unmapped  (err_unmapped)
  );

  // BRAM with RD_LAT-cycle registered read; two words preloaded while in reset.
  logic [7:0] mem [0:8191];
  logic [7:0] rd_stage [RD_LAT];
  always @(posedge clk) begin
    if (rst) begin
      mem[16] <= 8'h55;
      mem[17] <= 8'h66;
    end else if (bram_we) begin
      mem[bram_addr] <= bram_din;
    end
    rd_stage[0] <= mem[bram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_stage[i] <= rd_stage[i-1];
  end
  assign bram_dout = rd_stage[RD_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // Store queue contents, owned by the stimulus process.
  logic [15:0] qa [$];
  logic [7:0]  qd [$];
  bit          pop_pend = 1'b0;

  task automatic refresh();
    cpu_empty = (qa.size() == 0);
    cpu_addr  = cpu_empty ? 16'h0 : qa[0];
    cpu_data  = cpu_empty ? 8'h0 : qd[0];
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    qa.push_back(a);
    qd.push_back(d);
    refresh();
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (pop_pend) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      refresh();
    end
  endtask

  // Reference model: who may use the RAM, and what the port must show.
  localparam int MODE_CPU = 0, MODE_FLUSH = 1, MODE_SHARED = 2;
  int          m_mode   = MODE_CPU;
  int          m_streak = 0;
  bit          m_live   = 1'b0;
  logic [12:0] m_addr   = '0;
  logic [7:0]  m_din    = '0;
  bit          m_we     = 1'b0;
  bit          m_err    = 1'b0;
  logic [7:0]  shadow [0:8191];
  int          due_q [$];
  logic [7:0]  dat_q [$];

  // Per-cycle logs: 0 idle, 1 CPU grant, 2 VG grant; flushing; rvalid; rdata.
  int         ev_log [$];
  int         fl_log [$];
  int         rv_log [$];
  logic [7:0] rd_log [$];

  always @(negedge clk) begin
    bit has_entry, e_cpu, e_vg, e_rv;
    cycle++;
    has_entry = (qa.size() != 0);
    e_cpu = 1'b0;
    e_vg  = 1'b0;
    if (!rst) begin
      if (m_mode == MODE_FLUSH) begin
        e_cpu = has_entry;
      end else if (m_mode == MODE_SHARED) begin
        e_vg  = vg_req && !(has_entry && m_streak >= STARVE_LIMIT);
        e_cpu = has_entry && !e_vg;
      end else begin
        e_cpu = has_entry;
        e_vg  = !has_entry && vg_req;
      end
    end
    e_rv = (due_q.size() != 0) && (due_q[0] == cycle);

    if (m_live) begin
      chk("cpu_can_write", 32'(cpu_can_write), 32'(e_cpu));
      chk("vg_ack", 32'(vg_ack), 32'(e_vg));
      chk("flushing", 32'(flushing), 32'(m_mode == MODE_FLUSH));
      chk("bram_addr", 32'(bram_addr), 32'(m_addr));
      chk("bram_din", 32'(bram_din), 32'(m_din));
      chk("bram_we", 32'(bram_we), 32'(m_we));
      chk("err_unmapped", 32'(err_unmapped), 32'(m_err));
      chk("vg_rvalid", 32'(vg_rvalid), 32'(e_rv));
      if (e_rv) begin
        chk("vg_rdata", 32'(vg_rdata), 32'(dat_q[0]));
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      ev_log.push_back(cpu_can_write ? 1 : (vg_ack ? 2 : 0));
      fl_log.push_back(int'(flushing));
      rv_log.push_back(int'(vg_rvalid));
      rd_log.push_back(vg_rdata);
    end
    pop_pend = cpu_can_write;

    if (rst) begin
      m_live = 1'b1; m_mode = MODE_CPU; m_streak = 0;
      m_addr = '0; m_din = '0; m_we = 1'b0; m_err = 1'b0;
      due_q.delete(); dat_q.delete();
      shadow[16] = 8'h55;
      shadow[17] = 8'h66;
    end else begin
      m_we = 1'b0;
      if (e_cpu) begin
        m_addr = qa[0][12:0];
        m_din  = qd[0];
        if (qa[0] >= 16'h2000 && qa[0] <= 16'h3FFF) begin
          m_we = 1'b1;
          shadow[qa[0][12:0]] = qd[0];
        end else begin
          m_err = 1'b1;
        end
        m_streak = 0;
      end else if (e_vg) begin
        m_addr = vg_addr;
        due_q.push_back(cycle + 1 + RD_LAT);
        dat_q.push_back(shadow[vg_addr]);
        if (has_entry && m_streak < STARVE_LIMIT) m_streak++;
      end
      if (vg_go) begin
        m_mode = MODE_FLUSH;
        m_streak = 0;
      end else if (m_mode == MODE_FLUSH && !has_entry) m_mode = MODE_SHARED;
      else if (m_mode == MODE_SHARED && !vg_busy) m_mode = MODE_CPU;
      else if (m_mode == MODE_CPU && vg_busy) m_mode = MODE_SHARED;
    end
  end

  initial begin
    int idx;
    int want [];
    for (int i = 0; i < 8192; i++) shadow[i] = 8'h00;
    refresh();
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset bram_we", 32'(bram_we), 32'h0);
    chk("reset bram_addr", 32'(bram_addr), 32'h0);
    chk("reset flushing", 32'(flushing), 32'h0);
    chk("reset err_unmapped", 32'(err_unmapped), 32'h0);

    // Plain CPU drain of three in-window entries.
    idx = ev_log.size();
    push(16'h2000, 8'hA1);
    push(16'h2001, 8'hB2);
    push(16'h3FFF, 8'hC3);
    tick(6);
    want = '{1, 1, 1, 0};
    foreach (want[i]) chk("drain grant seq", 32'(ev_log[idx+i]), 32'(want[i]));
    chk("mem 0x0000", 32'(mem[13'h0000]), 32'hA1);
    chk("mem 0x0001", 32'(mem[13'h0001]), 32'hB2);
    chk("mem 0x1FFF", 32'(mem[13'h1FFF]), 32'hC3);
    chk("drain err", 32'(err_unmapped), 32'h0);

    // Start strobe with five queued stores and the generator already asking.
    for (int i = 0; i < 5; i++) push(16'h2100 + 16'(i), 8'h10 + 8'(i));
    vg_req = 1'b1; vg_busy = 1'b1; vg_go = 1'b1;
    idx = ev_log.size();
    tick(1);
    vg_go = 1'b0;
    tick(8);
    want = '{1, 1, 1, 1, 1, 0, 2};
    foreach (want[i]) chk("flush grant seq", 32'(ev_log[idx+i]), 32'(want[i]));
    want = '{0, 1, 1, 1, 1, 1, 0};
    foreach (want[i]) chk("flush flag seq", 32'(fl_log[idx+i]), 32'(want[i]));

    // Starvation bound: one CPU store waits behind exactly four VG grants.
    idx = ev_log.size();
    push(16'h2200, 8'h5A);
    tick(8);
    want = '{2, 2, 2, 2, 1, 2};
    foreach (want[i]) chk("starve seq", 32'(ev_log[idx+i]), 32'(want[i]));
    chk("mem 0x0200", 32'(mem[13'h0200]), 32'h5A);

    // Back-to-back reads of two preloaded words.
    vg_req = 1'b0;
    tick(3);
    vg_req = 1'b1; vg_addr = 13'h010;
    idx = ev_log.size();
    tick(1);
    vg_addr = 13'h011;
    tick(1);
    vg_req = 1'b0;
    tick(7);
    want = '{2, 2, 0};
    foreach (want[i]) chk("read ack seq", 32'(ev_log[idx+i]), 32'(want[i]));
    want = '{0, 0, 0, 1, 1, 0};
    foreach (want[i]) chk("rvalid timing", 32'(rv_log[idx+i]), 32'(want[i]));
    chk("rdata 0x010", 32'(rd_log[idx+3]), 32'h55);
    chk("rdata 0x011", 32'(rd_log[idx+4]), 32'h66);

    // Out-of-window store is popped without a write and flags the error.
    vg_busy = 1'b0;
    tick(2);
    idx = ev_log.size();
    push(16'h1820, 8'h77);
    tick(4);
    chk("unmapped popped", 32'(ev_log[idx]), 32'h1);
    chk("unmapped no write", 32'(mem[13'h1820]), 32'h00);
    chk("unmapped err set", 32'(err_unmapped), 32'h1);
    tick(5);
    chk("unmapped err sticky", 32'(err_unmapped), 32'h1);

    // Start strobe on an empty queue: a single flush cycle.
    vg_busy = 1'b1; vg_go = 1'b1;
    idx = ev_log.size();
    tick(1);
    vg_go = 1'b0;
    tick(3);
    want = '{0, 1, 0};
    foreach (want[i]) chk("empty flush seq", 32'(fl_log[idx+i]), 32'(want[i]));

    // Reset one cycle after a read grant discards the read.
    vg_req = 1'b1; vg_addr = 13'h010;
    idx = ev_log.size();
    tick(1);
    vg_req = 1'b0; rst = 1'b1; vg_busy = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("pre-reset ack", 32'(ev_log[idx]), 32'h2);
    for (int i = 0; i < 9; i++) chk("no rvalid after reset", 32'(rv_log[idx+i]), 32'h0);
    chk("post-reset err", 32'(err_unmapped), 32'h0);
    chk("post-reset bram_addr", 32'(bram_addr), 32'h0);
    chk("post-reset bram_we", 32'(bram_we), 32'h0);
    chk("post-reset flushing", 32'(flushing), 32'h0);

    // CPU-only state after reset: a store beats a simultaneous read request.
    idx = ev_log.size();
    push(16'h2300, 8'h3C);
    vg_req = 1'b1; vg_addr = 13'h011;
    tick(1);
    vg_req = 1'b0;
    tick(4);
    chk("cpu-only priority", 32'(ev_log[idx]), 32'h1);
    chk("mem 0x0300", 32'(mem[13'h0300]), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
